// File: rtl/soc_system_poller_pkg.sv
// Shared types and constants for the pushbutton PIO poller.
package soc_system_poller_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    WAIT = 2'd2,
    EVAL = 2'd3
  } state_e;

  localparam int DBC_CNT_W = 4;
  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

endpackage

// File: rtl/soc_system_debounce_bit.sv
// Single-bit debouncer: stable level changes only after DEBOUNCE_N consecutive differing samples.
module soc_system_debounce_bit
  import soc_system_poller_pkg::*;
#(
  parameter int DEBOUNCE_N = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic eval,
  input  logic sample,
  output logic stable,
  output logic rise,
  output logic fall
);

  logic [DBC_CNT_W-1:0] cnt_q, cnt_d;
  logic [DBC_CNT_W-1:0] cnt_inc;
  logic stable_q, stable_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    cnt_inc  = cnt_q + DBC_CNT_W'(1);
    if (eval) begin
      if (sample == stable_q) begin
        cnt_d = '0;
      end else if (cnt_inc == DBC_CNT_W'(DEBOUNCE_N)) begin
        stable_d = sample;
        cnt_d    = '0;
        rise_d   = sample;
        fall_d   = ~sample;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign stable = stable_q;
  assign rise   = rise_q;
  assign fall   = fall_q;

endmodule

// File: rtl/soc_system_button_poller.sv
// Avalon-MM read master that periodically samples the pushbutton PIO and
// debounces each key into level and press/release pulses.
module soc_system_button_poller
  import soc_system_poller_pkg::*;
#(
  parameter int DATA_W       = 4,
  parameter int POLL_DIV     = 50000,
  parameter int READ_LATENCY = 1,
  parameter int DEBOUNCE_N   = 4,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [1:0]        avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  output logic [DATA_W-1:0] buttons,
  output logic [DATA_W-1:0] press,
  output logic [DATA_W-1:0] release_evt,
  output logic              sample_valid
);

  localparam int TCW = $clog2(POLL_DIV);
  localparam int LW  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  logic [TCW-1:0]    tick_cnt_q, tick_cnt_d;
  logic              tick;
  state_e            state_q, state_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic              avm_read_q, avm_read_d;
  logic              sample_valid_q, sample_valid_d;
  logic              eval_stb;
  logic [DATA_W-1:0] sample;
  logic [31:DATA_W]  unused_rdata_hi;

  assign unused_rdata_hi = avm_readdata[31:DATA_W];

  always_comb begin
    tick       = (tick_cnt_q == TCW'(POLL_DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + TCW'(1);
  end

  // The debounce update fires on the last WAIT cycle so that its registered
  // outputs are visible while the FSM sits in EVAL.
  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    eval_stb = 1'b0;
    unique case (state_q)
      IDLE: if (tick && enable) state_d = READ;
      READ: begin
        if (!avm_waitrequest) begin
          state_d = WAIT;
          lat_d   = '0;
        end
      end
      WAIT: begin
        if (lat_q == LW'(READ_LATENCY - 1)) begin
          eval_stb = 1'b1;
          state_d  = EVAL;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      EVAL: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    avm_read_d     = (state_d == READ);
    sample_valid_d = eval_stb;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q     <= '0;
      state_q        <= IDLE;
      lat_q          <= '0;
      avm_read_q     <= 1'b0;
      sample_valid_q <= 1'b0;
    end else begin
      tick_cnt_q     <= tick_cnt_d;
      state_q        <= state_d;
      lat_q          <= lat_d;
      avm_read_q     <= avm_read_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign sample = avm_readdata[DATA_W-1:0] ^ {DATA_W{ACTIVE_LOW}};

  for (genvar i = 0; i < DATA_W; i++) begin : g_bit
    soc_system_debounce_bit #(
      .DEBOUNCE_N(DEBOUNCE_N)
    ) u_bit (
      .clk   (clk),
      .reset (reset),
      .eval  (eval_stb),
      .sample(sample[i]),
      .stable(buttons[i]),
      .rise  (press[i]),
      .fall  (release_evt[i])
    );
  end

  assign avm_address  = PIO_DATA_ADDR;
  assign avm_read     = avm_read_q;
  assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_soc_system_button_poller.sv
// Directed bench for the button poller: latency-1 instance with debounce 4,
// plus a latency-3 instance with debounce 1 to expose the captured sample.
module tb_soc_system_button_poller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en_a, wr_a, en_b;
  logic [31:0] rd_a, rd_b, good_b;
  logic [1:0]  a_addr, b_addr;
  logic        a_read, a_sv, b_read, b_sv;
  logic [3:0]  a_btn, a_pr, a_rl, b_btn, b_pr, b_rl;
  logic [2:0]  acc = '0;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [3:0] g_pr, g_rl, g_bt, g_pr_n, g_rl_n;

  soc_system_button_poller #(
    .DATA_W(4), .POLL_DIV(8), .READ_LATENCY(1), .DEBOUNCE_N(4), .ACTIVE_LOW(1'b1)
  ) dut_a (
    .clk(clk), .reset(rst), .enable(en_a),
    .avm_address(a_addr), .avm_read(a_read), .avm_waitrequest(wr_a),
    .avm_readdata(rd_a), .buttons(a_btn), .press(a_pr), .release_evt(a_rl),
    .sample_valid(a_sv)
  );

  soc_system_button_poller #(
    .DATA_W(4), .POLL_DIV(8), .READ_LATENCY(3), .DEBOUNCE_N(1), .ACTIVE_LOW(1'b1)
  ) dut_b (
    .clk(clk), .reset(rst), .enable(en_b),
    .avm_address(b_addr), .avm_read(b_read), .avm_waitrequest(1'b0),
    .avm_readdata(rd_b), .buttons(b_btn), .press(b_pr), .release_evt(b_rl),
    .sample_valid(b_sv)
  );

  // Slave for the latency-3 instance: good data only on the 3rd cycle after acceptance.
  always @(posedge clk) acc <= {acc[1:0], b_read};
  assign rd_b = acc[2] ? good_b : ~good_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_read_a(output int n);
    n = 0;
    while (!a_read && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("read_a_seen", 32'(n < 40), 1);
  endtask

  task automatic poll_a();
    int n = 0;
    @(negedge clk);
    while (!a_sv && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("poll_a_done", 32'(n < 40), 1);
    g_pr = a_pr;
    g_rl = a_rl;
    g_bt = a_btn;
    @(negedge clk);
    g_pr_n = a_pr;
    g_rl_n = a_rl;
  endtask

  task automatic poll_b();
    int n = 0;
    @(negedge clk);
    while (!b_sv && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("poll_b_done", 32'(n < 60), 1);
  endtask

  initial begin
    int n;
    logic seen_rd;
    logic [3:0] acc_pr, acc_bt;
    int hi, svc;

    rst = 1'b1; en_a = 1'b0; en_b = 1'b0; wr_a = 1'b0;
    rd_a = 32'hF; good_b = 32'hF;
    repeat (3) @(negedge clk);
    check("rst_read", a_read, 0);
    check("rst_addr", a_addr, 0);
    check("rst_outs", {a_btn, a_pr, a_rl, 3'b0, a_sv}, 0);
    check("rst_b", {b_read, b_btn}, 0);
    rst = 1'b0;

    seen_rd = 1'b0; acc_bt = '0;
    repeat (24) begin
      @(negedge clk);
      seen_rd |= a_read;
      acc_bt  |= a_btn | a_pr | a_rl | {3'b0, a_sv};
    end
    check("idle_no_read", seen_rd, 0);
    check("idle_outs", acc_bt, 0);

    // Tick-to-EVAL latency: read in T+1, single-cycle, sample_valid in T+3.
    en_a = 1'b1;
    wait_read_a(n);
    check("addr_zero", a_addr, 0);
    @(negedge clk);
    check("read_one_cycle", {a_read, a_sv}, 2'b00);
    @(negedge clk);
    check("eval_t3", a_sv, 1);
    check("eval_t3_btn", a_btn, 0);
    wait_read_a(n);
    check("tick_period", n, 6);

    // Key 0 pressed: press on the 4th poll.
    rd_a = 32'hE;
    acc_pr = '0; acc_bt = '0;
    for (int p = 0; p < 3; p++) begin
      poll_a();
      acc_pr |= g_pr;
      acc_bt |= g_bt;
    end
    check("press_early", {acc_pr, acc_bt}, 0);
    poll_a();
    check("press_4th", g_pr, 4'b0001);
    check("press_btn", g_bt, 4'b0001);
    check("press_one_cycle", g_pr_n, 0);
    poll_a();
    check("press_no_repeat", {g_pr, g_bt}, 8'h01);

    rd_a = 32'hF;
    for (int p = 0; p < 3; p++) poll_a();
    poll_a();
    check("release_4th", {g_rl, g_bt, g_pr}, 12'h100);
    check("release_one_cycle", g_rl_n, 0);

    // Bounce: alternating samples never reach the threshold.
    acc_pr = '0; acc_bt = '0;
    for (int k = 0; k < 10; k++) begin
      rd_a = (k % 2 == 0) ? 32'hE : 32'hF;
      poll_a();
      acc_pr |= g_pr;
      acc_bt |= g_bt;
    end
    check("bounce_press", acc_pr, 0);
    check("bounce_btn", acc_bt, 0);

    // Two keys together, upper readdata bits ignored.
    rd_a = 32'hABCD_FFF5;
    acc_pr = '0;
    for (int p = 0; p < 3; p++) begin
      poll_a();
      acc_pr |= g_pr;
    end
    poll_a();
    check("multi_early", acc_pr, 0);
    check("multi_press", g_pr, 4'hA);
    check("multi_btn", g_bt, 4'hA);

    // Waitrequest stall of 5 cycles; tick landing in EVAL is dropped.
    wr_a = 1'b1;
    wait_read_a(n);
    hi = 0; svc = 0;
    for (int c = 0; c < 16; c++) begin
      if (a_read) hi++;
      if (a_sv) svc++;
      if (hi == 6 && wr_a) wr_a = 1'b0;
      @(negedge clk);
    end
    wr_a = 1'b0;
    check("stall_read_cycles", hi, 6);
    check("stall_one_sample", svc, 1);
    check("stall_next_read", a_read, 1);

    // Enable dropped mid-read: read completes, no further reads.
    en_a = 1'b0;
    poll_a();
    check("drop_btn", g_bt, 4'hA);
    seen_rd = 1'b0;
    repeat (24) begin
      @(negedge clk);
      seen_rd |= a_read;
    end
    check("drop_no_read", seen_rd, 0);

    // Reset while a stalled read is pending.
    en_a = 1'b1; wr_a = 1'b1;
    wait_read_a(n);
    @(negedge clk);
    check("stall_hold", a_read, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_read", a_read, 0);
    check("rst_mid_btn", {a_btn, 3'b0, a_sv}, 0);
    rst = 1'b0; wr_a = 1'b0;
    @(negedge clk);
    n = 1;
    while (!a_read && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("resume_tick", n, 8);
    for (int p = 0; p < 3; p++) poll_a();
    poll_a();
    check("resume_press", {g_pr, g_bt}, 8'hAA);

    // Latency-3 capture on the second instance.
    good_b = 32'hE;
    en_b = 1'b1;
    poll_b();
    check("lat3_btn", b_btn, 4'h1);
    check("lat3_press", b_pr, 4'h1);
    check("lat3_addr", b_addr, 0);
    @(negedge clk);
    good_b = 32'h9;
    poll_b();
    check("lat3_btn2", b_btn, 4'h6);
    check("lat3_evt2", {b_pr, b_rl}, 8'h61);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
